// File: rtl/alu_seq_if.sv
// Request/response bundle between an ALU op issuer (master) and alu_op_sequencer (slave).
interface alu_seq_if #(
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_opcode;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_carry;
    logic              rsp_zero;
    logic [7:0]        rsp_ctrl;
    logic              rsp_branch;
    logic              rsp_store;

    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero,
               rsp_ctrl, rsp_branch, rsp_store
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero,
               rsp_ctrl, rsp_branch, rsp_store
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU operation sequencer: accepts one op, decodes it through a
// 16-entry control table, executes (bit-serial shifts by default) and returns
// a registered response.
// Optional macro ALU_SEQ_FAST_SHIFT_EN: single-cycle barrel shifter for
// shl/shr/rol/ror instead of one bit per cycle.
module alu_op_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SHAMT_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_RESP
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [3:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [7:0]          ctrl_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [DATA_W-1:0]   work_q;
    logic                carry_q;

    logic [3:0]          func;
    logic [SHAMT_W-1:0]  amt;
    logic                accept;
    logic                shift_iter;
    logic [DATA_W:0]     sum_w;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic                branch_taken;

    assign func   = ctrl_q[5:2];
    assign amt    = b_q[SHAMT_W-1:0];
    assign accept = bus.req_valid && bus.req_ready;
    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};

`ifdef ALU_SEQ_FAST_SHIFT_EN
    logic [SHAMT_W:0] rot_back;
    assign rot_back   = (SHAMT_W+1)'(DATA_W) - {1'b0, amt};
    assign shift_iter = 1'b0;
`else
    assign shift_iter = (func >= 4'd6) && (func <= 4'd9);
`endif

    // Opcode to control word: {2'b00, fn, 2'b01}, with jump/beq carrying extra flag bits.
    function automatic logic [7:0] ctrl_lookup(input logic [3:0] op);
        case (op)
            4'd14:   return 8'hF9;
            4'd15:   return 8'hFD;
            default: return {2'b00, op, 2'b01};
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; WB is the cycle that loads the response registers.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   if (!shift_iter || (cnt_q <= SHAMT_W'(1))) state_d = S_WB;
            S_WB:     state_d = S_RESP;
            S_RESP:   if (bus.rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Single-cycle ALU result from the captured operands.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        if (ctrl_q[0]) begin
            case (func)
                4'd0: {alu_carry, alu_res} = sum_w;
                4'd1: begin
                    alu_res   = a_q - b_q;
                    alu_carry = (a_q >= b_q);
                end
                4'd2: alu_res = a_q & b_q;
                4'd3: alu_res = a_q | b_q;
                4'd4: alu_res = a_q ^ b_q;
                4'd5: alu_res = ~a_q;
`ifdef ALU_SEQ_FAST_SHIFT_EN
                4'd6: {alu_carry, alu_res} = {1'b0, a_q} << amt;
                4'd7: {alu_res, alu_carry} = {a_q, 1'b0} >> amt;
                4'd8: begin
                    alu_res   = (a_q << amt) | (a_q >> rot_back);
                    alu_carry = (amt != '0) && alu_res[0];
                end
                4'd9: begin
                    alu_res   = (a_q >> amt) | (a_q << rot_back);
                    alu_carry = (amt != '0) && alu_res[DATA_W-1];
                end
`endif
                4'd10, 4'd13, 4'd14, 4'd15: alu_res = b_q;
                4'd11, 4'd12:               alu_res = a_q;
                default: ;
            endcase
        end
    end

    // Control-flow decision from the captured operands.
    always_comb begin
        branch_taken = 1'b0;
        case (func)
            4'd13:   branch_taken = (a_q != '0);
            4'd14:   branch_taken = 1'b1;
            4'd15:   branch_taken = (a_q == b_q);
            default: branch_taken = 1'b0;
        endcase
    end

    // Operand capture, decode, execute and working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= bus.req_opcode;
                        a_q  <= bus.req_a;
                        b_q  <= bus.req_b;
                    end
                end
                S_DECODE: begin
                    ctrl_q  <= ctrl_lookup(op_q);
                    cnt_q   <= amt;
                    work_q  <= a_q;
                    carry_q <= 1'b0;
                end
                S_EXEC: begin
                    if (shift_iter) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - SHAMT_W'(1);
                            case (func)
                                4'd6: {carry_q, work_q} <= {work_q, 1'b0};
                                4'd7: {work_q, carry_q} <= {1'b0, work_q};
                                4'd8: begin
                                    work_q  <= {work_q[DATA_W-2:0], work_q[DATA_W-1]};
                                    carry_q <= work_q[DATA_W-1];
                                end
                                default: begin
                                    work_q  <= {work_q[0], work_q[DATA_W-1:1]};
                                    carry_q <= work_q[0];
                                end
                            endcase
                        end
                    end else begin
                        work_q  <= alu_res;
                        carry_q <= alu_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered handshake, status and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_ctrl   <= '0;
            bus.rsp_branch <= 1'b0;
            bus.rsp_store  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            bus.req_ready <= (state_d == S_IDLE);
            bus.rsp_valid <= (state_d == S_RESP);
            busy          <= (state_d != S_IDLE);
            if (state_q == S_WB) begin
                bus.rsp_result <= work_q;
                bus.rsp_carry  <= carry_q;
                bus.rsp_zero   <= (work_q == '0);
                bus.rsp_ctrl   <= ctrl_q;
                bus.rsp_branch <= branch_taken;
                bus.rsp_store  <= (func == 4'd12);
            end else if ((state_q == S_RESP) && bus.rsp_ready) begin
                bus.rsp_result <= '0;
                bus.rsp_carry  <= 1'b0;
                bus.rsp_zero   <= 1'b0;
                bus.rsp_ctrl   <= '0;
                bus.rsp_branch <= 1'b0;
                bus.rsp_store  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table plus reset, backpressure
// and early-ready sequences.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic busy;

    alu_seq_if #(.DATA_W(8)) bus ();

    alu_op_sequencer #(.DATA_W(8), .SHAMT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       carry;
        logic       zero;
        logic       branch;
        logic       store;
        logic [7:0] ctrl;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] op, input logic [7:0] b);
        int amt;
        amt = int'(b[2:0]);
        if (!FAST && (op >= 4'd6) && (op <= 4'd9))
            return 2 + ((amt == 0) ? 1 : amt);
        return 3;
    endfunction

    // Present a request, wait for the accept edge, then scramble the inputs.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_a      = a;
        bus.req_b      = b;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_opcode = 4'($urandom);
        bus.req_a      = 8'($urandom);
        bus.req_b      = 8'($urandom);
    endtask

    // Count edges after the accept edge until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(posedge clk); #1;
        chk($sformatf("v%0d_req_ready", idx), 32'(bus.req_ready), 32'd1);
        issue(v.op, v.a, v.b);
        wait_rsp(lat);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(exp_lat(v.op, v.b)));
        chk($sformatf("v%0d_result", idx), 32'(bus.rsp_result), 32'(v.res));
        chk($sformatf("v%0d_carry", idx),  32'(bus.rsp_carry),  32'(v.carry));
        chk($sformatf("v%0d_zero", idx),   32'(bus.rsp_zero),   32'(v.zero));
        chk($sformatf("v%0d_ctrl", idx),   32'(bus.rsp_ctrl),   32'(v.ctrl));
        chk($sformatf("v%0d_branch", idx), 32'(bus.rsp_branch), 32'(v.branch));
        chk($sformatf("v%0d_store", idx),  32'(bus.rsp_store),  32'(v.store));
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk($sformatf("v%0d_rsp_drop", idx), 32'(bus.rsp_valid), 32'd0);
        chk($sformatf("v%0d_idle", idx),     32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        logic [7:0] held;

        //           op     a      b      res    c     z     br    st    ctrl
        vecs[0]  = '{4'd0,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[1]  = '{4'd1,  8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05};
        vecs[2]  = '{4'd1,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05};
        vecs[3]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09};
        vecs[4]  = '{4'd3,  8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D};
        vecs[5]  = '{4'd4,  8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
        vecs[6]  = '{4'd5,  8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h15};
        vecs[7]  = '{4'd6,  8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 8'h19};
        vecs[8]  = '{4'd7,  8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1D};
        vecs[9]  = '{4'd8,  8'h81, 8'h01, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 8'h21};
        vecs[10] = '{4'd9,  8'h01, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 8'h25};
        vecs[11] = '{4'd6,  8'hA5, 8'hF8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h19};
        vecs[12] = '{4'd6,  8'h03, 8'h07, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 8'h19};
        vecs[13] = '{4'd9,  8'h96, 8'h07, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0, 8'h25};
        vecs[14] = '{4'd10, 8'h11, 8'h77, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'h29};
        vecs[15] = '{4'd11, 8'h00, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h2D};
        vecs[16] = '{4'd12, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31};
        vecs[17] = '{4'd13, 8'h00, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 8'h35};
        vecs[18] = '{4'd13, 8'h01, 8'h40, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 8'h35};
        vecs[19] = '{4'd14, 8'h00, 8'h22, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF9};
        vecs[20] = '{4'd15, 8'h3C, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFD};
        vecs[21] = '{4'd15, 8'h3C, 8'h3D, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFD};
        vecs[22] = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[23] = '{4'd8,  8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21};

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_req_ready", 32'(bus.req_ready),  32'd1);
        chk("reset_busy",      32'(busy),           32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid),  32'd0);
        chk("reset_result",    32'(bus.rsp_result), 32'd0);
        chk("reset_ctrl",      32'(bus.rsp_ctrl),   32'd0);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Reset during EXEC of a 5-bit shl: no response may ever appear.
        issue(4'd6, 8'h81, 8'h05);
        @(posedge clk); #1;
        chk("rst_mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",      32'(busy),          32'd0);
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) cnt++;
        end
        chk("rst_mid_no_rsp", 32'(cnt), 32'd0);

        // Backpressure with a queued request waiting behind the response.
        issue(4'd0, 8'h10, 8'h20);
        wait_rsp(lat);
        chk("bp_latency", 32'(lat), 32'd3);
        bus.req_valid  = 1'b1;
        bus.req_opcode = 4'd10;
        bus.req_a      = 8'h00;
        bus.req_b      = 8'h99;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_rsp_valid", k), 32'(bus.rsp_valid),  32'd1);
            chk($sformatf("bp%0d_result", k),    32'(bus.rsp_result), 32'h30);
            chk($sformatf("bp%0d_ctrl", k),      32'(bus.rsp_ctrl),   32'h01);
            chk($sformatf("bp%0d_req_ready", k), 32'(bus.req_ready),  32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("bp_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_hs_req_ready", 32'(bus.req_ready), 32'd1);
        chk("bp_hs_busy",      32'(busy),          32'd0);
        @(posedge clk); #1;
        chk("bp_queued_accepted", 32'(bus.req_ready), 32'd0);
        chk("bp_queued_busy",     32'(busy),          32'd1);
        bus.req_valid = 1'b0;
        bus.req_b     = 8'h00;
        wait_rsp(lat);
        chk("bp_queued_latency", 32'(lat),            32'd3);
        chk("bp_queued_result",  32'(bus.rsp_result), 32'h99);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;

        // rsp_ready high in advance: exactly one RESP cycle.
        bus.rsp_ready = 1'b1;
        issue(4'd4, 8'hAA, 8'hFF);
        cnt  = 0;
        held = 8'h00;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) begin
                cnt++;
                held = bus.rsp_result;
            end
        end
        bus.rsp_ready = 1'b0;
        chk("early_ready_resp_cycles", 32'(cnt),  32'd1);
        chk("early_ready_result",      32'(held), 32'h55);
        chk("early_ready_idle",        32'(bus.req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
